seg_display_arbiter: RTL and testbench

Shares the single four-digit `seg_driver` display between two requesters that each want to show a 16-bit value. Each requester raises a level request. The arbiter grants one requester round-robin and latches its value onto the `seg_driver` `bin` input. It then holds that value for a programmable number of clock cycles before the display can be re-arbitrated. The block sits directly upstream of `seg_driver`: its `bin` output connects to `seg_driver.bin`, and its `blank` output gates the segment enables at top level.

---
 rtl/seg_display_arbiter_if.sv | 22 ++
 rtl/seg_display_arbiter.sv | 93 +++++++++
 tb/tb_seg_display_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle for seg_display_arbiter. The slave modport is the arbiter's view.
// The master modport is the requester/top-level view.
interface seg_display_arbiter_if;
  logic [1:0]  req;
  logic [15:0] val0;
  logic [15:0] val1;
  logic [1:0]  ack;
  logic        owner;
  logic        busy;
  logic [15:0] bin;
  logic        blank;

  modport master (
    output req, val0, val1,
    input  ack, owner, busy, bin, blank
  );

  modport slave (
    input  req, val0, val1,
    output ack, owner, busy, bin, blank
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one seg_driver between two requesters.
// A granted value is held on the display for HOLD_CYCLES cycles before re-arbitration.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CW          = 26
) (
  input  logic                  clock,
  input  logic                  reset_n,
  seg_display_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_e;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          last_q,  last_d;
  logic [15:0]   bin_q,   bin_d;
  logic          blank_q, blank_d;
  logic [1:0]    ack_q,   ack_d;
  logic          owner_q, owner_d;
  logic          busy_q,  busy_d;
  logic          winner;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;  // requester 0 wins the first tie after reset
      bin_q   <= '0;
      blank_q <= 1'b1;
      ack_q   <= '0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      bin_q   <= bin_d;
      blank_q <= blank_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    bin_d   = bin_q;
    blank_d = blank_q;
    ack_d   = '0;
    owner_d = owner_q;
    busy_d  = busy_q;
    winner  = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          bin_d         = winner ? bus.val1 : bus.val0;
          ack_d[winner] = 1'b1;
          owner_d       = winner;
          last_d        = winner;
          blank_d       = 1'b0;
          busy_d        = 1'b1;
          cnt_d         = HOLD_LOAD;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bin   = bin_q;
  assign bus.blank = blank_q;
  assign bus.ack   = ack_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based reference model.
module tb_seg_display_arbiter;

  localparam int H  = 4;
  localparam int CW = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(.HOLD_CYCLES(H), .CW(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: outputs derived from the edge count and the time of the last grant.
  int          m_t;
  int          m_grant_t;
  bit          m_granted;
  bit          m_last;
  bit          m_owner;
  bit          m_blank;
  logic [15:0] m_bin;

  task automatic model_reset();
    m_t       = 0;
    m_grant_t = 0;
    m_granted = 1'b0;
    m_last    = 1'b1;
    m_owner   = 1'b0;
    m_blank   = 1'b1;
    m_bin     = 16'h0000;
  endtask

  task automatic model_edge();
    bit w;
    m_t++;
    if ((!m_granted || m_t >= m_grant_t + H + 1) && bus.req != 2'b00) begin
      if (bus.req == 2'b11) w = !m_last;
      else                  w = bus.req[1];
      m_bin     = w ? bus.val1 : bus.val0;
      m_owner   = w;
      m_last    = w;
      m_blank   = 1'b0;
      m_granted = 1'b1;
      m_grant_t = m_t;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0] e_ack;
    logic       e_busy;
    e_busy = m_granted && (m_t < m_grant_t + H);
    e_ack  = (m_granted && m_t == m_grant_t) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    check({tag, "_bin"},   32'(bus.bin),   32'(m_bin));
    check({tag, "_blank"}, 32'(bus.blank), 32'(m_blank));
    check({tag, "_ack"},   32'(bus.ack),   32'(e_ack));
    check({tag, "_owner"}, 32'(bus.owner), 32'(m_owner));
    check({tag, "_busy"},  32'(bus.busy),  32'(e_busy));
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs(tag);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(negedge clock);
      check_outputs("rst");
    end
    reset_n = 1'b1;
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.val0 = 16'h0000;
    bus.val1 = 16'h0000;

    // Reset values
    do_reset(3);
    repeat (5) cycle("idle");

    // Single grant; value persists after the request drops
    bus.req  = 2'b01;
    bus.val0 = 16'd20;
    cycle("single");
    check("single_ack_expl", 32'(bus.ack), 32'h1);
    check("single_bin_expl", 32'(bus.bin), 32'd20);
    bus.req = 2'b00;
    repeat (6) cycle("single_after");
    check("single_bin_kept", 32'(bus.bin), 32'd20);

    // Simultaneous request: alternation 0,1,0,1 every H+1 cycles
    do_reset(2);
    bus.req  = 2'b11;
    bus.val0 = 16'h1234;
    bus.val1 = 16'hBEEF;
    for (int g = 0; g < 4; g++) begin
      cycle("simul");
      check("simul_owner_expl", 32'(bus.owner), 32'(g % 2));
      check("simul_bin_expl", 32'(bus.bin), (g % 2) ? 32'hBEEF : 32'h1234);
      repeat (H) cycle("simul_hold");
    end

    // Request during HOLD is serviced at the first IDLE edge
    bus.req  = 2'b01;
    bus.val0 = 16'h0055;
    cycle("dur_grant");
    bus.req = 2'b00;
    repeat (2) cycle("dur_hold");
    bus.req  = 2'b10;
    bus.val1 = 16'd7;
    repeat (2) begin
      cycle("dur_wait");
      check("dur_bin_held", 32'(bus.bin), 32'h55);
    end
    cycle("dur_grant1");
    check("dur_ack_expl", 32'(bus.ack), 32'h2);
    check("dur_bin_expl", 32'(bus.bin), 32'd7);
    bus.req = 2'b00;
    repeat (H + 1) cycle("dur_tail");

    // Value change during HOLD is ignored
    bus.req  = 2'b01;
    bus.val0 = 16'd5;
    cycle("vchg_grant");
    bus.req  = 2'b00;
    bus.val0 = 16'd9;
    repeat (H) begin
      cycle("vchg_hold");
      check("vchg_bin_expl", 32'(bus.bin), 32'd5);
    end
    cycle("vchg_idle");

    // Asynchronous reset two cycles into HOLD
    bus.req  = 2'b10;
    bus.val1 = 16'h0077;
    cycle("rmid_grant");
    repeat (2) cycle("rmid_hold");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("rmid_bin_async",   32'(bus.bin),   32'h0);
    check("rmid_blank_async", 32'(bus.blank), 32'h1);
    check("rmid_busy_async",  32'(bus.busy),  32'h0);
    check("rmid_ack_async",   32'(bus.ack),   32'h0);
    @(negedge clock);
    check_outputs("rmid_rst");
    reset_n  = 1'b1;
    bus.req  = 2'b11;
    bus.val0 = 16'hAAAA;
    bus.val1 = 16'hBBBB;
    cycle("rmid_after");
    check("rmid_owner_first", 32'(bus.owner), 32'h0);
    check("rmid_ack_first",   32'(bus.ack),   32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) != 0) bus.req = 2'($urandom);
      bus.val0 = 16'($urandom);
      bus.val1 = 16'($urandom);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
